// File: rtl/bcpu_alu_pipe.sv
// BCPU execute-stage ALU: parametrised width/latency, flags and thread tag pipelined with result.
// Define BCPU_ALU_PIPE_MUL_EN to implement the multiply opcodes (10-13); otherwise they return 0.

module bcpu_alu_pipe #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned LATENCY    = 3,
    parameter int unsigned TAG_WIDTH  = 2
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  CE,
    input  logic                  ALU_EN,
    input  logic [3:0]            ALU_OP,
    input  logic [DATA_WIDTH-1:0] A_IN,
    input  logic [DATA_WIDTH-1:0] B_IN,
    input  logic [3:0]            FLAGS_IN,
    input  logic [TAG_WIDTH-1:0]  TAG_IN,
    output logic [DATA_WIDTH-1:0] ALU_OUT,
    output logic [3:0]            FLAGS_OUT,
    output logic [TAG_WIDTH-1:0]  TAG_OUT,
    output logic                  VALID_OUT
);
    localparam int unsigned W      = DATA_WIDTH;
    localparam int unsigned ShiftW = $clog2(DATA_WIDTH);
    localparam int          Depth  = int'(LATENCY) - 1;

    localparam int FlV = 3;
    localparam int FlS = 2;
    localparam int FlZ = 1;
    localparam int FlC = 0;

    typedef enum logic [3:0] {
        OpInc, OpDec, OpAdd, OpAddc, OpSub, OpSubc, OpAnd, OpAndn,
        OpOr, OpXor, OpMul, OpMulhsu, OpMulhss, OpMulhuu, OpShl, OpShr
    } alu_op_e;

    // Input capture stage; the ALU evaluates combinationally from these registers.
    logic                 en_q;
    alu_op_e              op_q;
    logic [W-1:0]         a_q;
    logic [W-1:0]         b_q;
    logic [3:0]           fl_q;
    logic [TAG_WIDTH-1:0] tag_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            en_q  <= 1'b0;
            op_q  <= OpInc;
            a_q   <= '0;
            b_q   <= '0;
            fl_q  <= '0;
            tag_q <= '0;
        end else if (CE) begin
            en_q  <= ALU_EN;
            op_q  <= alu_op_e'(ALU_OP);
            a_q   <= A_IN;
            b_q   <= B_IN;
            fl_q  <= FLAGS_IN;
            tag_q <= TAG_IN;
        end
    end

`ifdef BCPU_ALU_PIPE_MUL_EN
    // One 2W-bit multiplier; operand extension selects the signedness of the high half.
    logic [2*W-1:0] mul_a;
    logic [2*W-1:0] mul_b;
    logic [2*W-1:0] prod;

    always_comb begin
        mul_a = {{W{1'b0}}, a_q};
        mul_b = {{W{1'b0}}, b_q};
        if (op_q == OpMulhsu || op_q == OpMulhss) mul_a = {{W{a_q[W-1]}}, a_q};
        if (op_q == OpMulhss) mul_b = {{W{b_q[W-1]}}, b_q};
    end

    assign prod = mul_a * mul_b;
`endif

    logic [W:0]        sum;
    logic [W:0]        diff;
    logic [W:0]        shl_ext;
    logic [W:0]        shr_ext;
    logic [ShiftW-1:0] shamt;
    logic              cin;
    logic              upd_sz;
    logic [W-1:0]      res;
    logic [3:0]        fl;

    always_comb begin
        shamt   = b_q[ShiftW-1:0];
        cin     = fl_q[FlC] & ((op_q == OpAddc) | (op_q == OpSubc));
        sum     = {1'b0, a_q} + {1'b0, b_q} + {{W{1'b0}}, cin};
        diff    = {1'b0, a_q} - {1'b0, b_q} - {{W{1'b0}}, cin};
        // Extra bit on the outgoing side captures the last bit shifted out.
        shl_ext = {1'b0, a_q} << shamt;
        shr_ext = {a_q, 1'b0} >> shamt;
        res     = '0;
        fl      = fl_q;
        upd_sz  = 1'b0;
        if (en_q) begin
            unique case (op_q)
                OpInc: res = sum[W-1:0];
                OpDec: res = diff[W-1:0];
                OpAdd, OpAddc: begin
                    res     = sum[W-1:0];
                    fl[FlC] = sum[W];
                    fl[FlV] = (a_q[W-1] == b_q[W-1]) && (sum[W-1] != a_q[W-1]);
                    upd_sz  = 1'b1;
                end
                OpSub, OpSubc: begin
                    res     = diff[W-1:0];
                    fl[FlC] = diff[W];
                    fl[FlV] = (a_q[W-1] != b_q[W-1]) && (diff[W-1] != a_q[W-1]);
                    upd_sz  = 1'b1;
                end
                OpAnd: begin
                    res    = a_q & b_q;
                    upd_sz = 1'b1;
                end
                OpAndn: begin
                    res    = a_q & ~b_q;
                    upd_sz = 1'b1;
                end
                OpOr: begin
                    res    = a_q | b_q;
                    upd_sz = 1'b1;
                end
                OpXor: begin
                    res    = a_q ^ b_q;
                    upd_sz = 1'b1;
                end
`ifdef BCPU_ALU_PIPE_MUL_EN
                OpMul:                          res = prod[W-1:0];
                OpMulhsu, OpMulhss, OpMulhuu:   res = prod[2*W-1:W];
`else
                OpMul, OpMulhsu, OpMulhss, OpMulhuu: res = '0;
`endif
                OpShl: begin
                    res = shl_ext[W-1:0];
                    if (shamt != '0) fl[FlC] = shl_ext[W];
                    upd_sz = 1'b1;
                end
                OpShr: begin
                    res = shr_ext[W:1];
                    if (shamt != '0) fl[FlC] = shr_ext[0];
                    upd_sz = 1'b1;
                end
            endcase
            if (upd_sz) begin
                fl[FlS] = res[W-1];
                fl[FlZ] = (res == '0);
            end
        end
    end

    logic [W-1:0]         res_q [Depth];
    logic [3:0]           fl_pq [Depth];
    logic [TAG_WIDTH-1:0] tag_pq[Depth];
    logic                 vld_q [Depth];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < Depth; i++) begin
                res_q[i]  <= '0;
                fl_pq[i]  <= '0;
                tag_pq[i] <= '0;
                vld_q[i]  <= 1'b0;
            end
        end else if (CE) begin
            res_q[0]  <= res;
            fl_pq[0]  <= fl;
            tag_pq[0] <= tag_q;
            vld_q[0]  <= en_q;
            for (int i = 1; i < Depth; i++) begin
                res_q[i]  <= res_q[i-1];
                fl_pq[i]  <= fl_pq[i-1];
                tag_pq[i] <= tag_pq[i-1];
                vld_q[i]  <= vld_q[i-1];
            end
        end
    end

    assign ALU_OUT   = res_q[Depth-1];
    assign FLAGS_OUT = fl_pq[Depth-1];
    assign TAG_OUT   = tag_pq[Depth-1];
    assign VALID_OUT = vld_q[Depth-1];

endmodule
